// File: rtl/mac_sequencer.sv
// rtl/mac_sequencer.sv - dot-product job sequencer driving a MAC processing element
// Optional cycle counter enabled by defining MAC_SEQ_PERF_CNT_EN.
module mac_sequencer #(
    parameter int N = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [1:0]  cfg_dimen_i,
    input  logic        s_valid_i,
    output logic        s_ready_o,
    input  logic [31:0] s_data_i,
    output logic        r_valid_o,
    input  logic        r_ready_i,
    output logic [31:0] r_data_o,
    output logic        busy_o,
    output logic        rst_add_o,
    output logic        rst_acc_o,
    output logic        rst_pc_o,
    output logic        mat_mux_o,
    output logic        write_mat_o,
    output logic        mac_ctrl_o,
    output logic        out_ready_o,
    output logic [31:0] datain_o,
    output logic [1:0]  dimen_o,
    input  logic        mac_done_i,
    input  logic [31:0] dataout_i,
    output logic [15:0] perf_cycles_o
);

    typedef enum logic [2:0] {
        IDLE, CLR, LOAD_A, SWAP, LOAD_B, MAC, READ, RESULT
    } state_t;

    localparam logic [4:0] MAX_LEN = 5'(N);

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [1:0]  dimen_q, dimen_d;
    logic [31:0] res_q, res_d;
    logic [4:0]  len_raw, len, cnt_inc;

    // Word count per operand: 2 << code, never beyond the PE buffer depth.
    assign len_raw = 5'd2 << dimen_q;
    assign len     = (len_raw > MAX_LEN) ? MAX_LEN : len_raw;
    assign cnt_inc = cnt_q + 5'd1;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dimen_q <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dimen_q <= dimen_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dimen_d     = dimen_q;
        res_d       = res_q;
        s_ready_o   = 1'b0;
        r_valid_o   = 1'b0;
        rst_add_o   = 1'b0;
        rst_acc_o   = 1'b0;
        rst_pc_o    = 1'b0;
        mat_mux_o   = 1'b0;
        write_mat_o = 1'b0;
        mac_ctrl_o  = 1'b0;
        out_ready_o = 1'b0;
        datain_o    = '0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    dimen_d = cfg_dimen_i;
                    state_d = CLR;
                end
            end
            CLR: begin
                rst_add_o = 1'b1;
                rst_acc_o = 1'b1;
                rst_pc_o  = 1'b1;
                cnt_d     = '0;
                state_d   = LOAD_A;
            end
            LOAD_A, LOAD_B: begin
                s_ready_o   = 1'b1;
                mat_mux_o   = (state_q == LOAD_A);
                write_mat_o = s_valid_i;
                datain_o    = s_data_i;
                if (s_valid_i) begin
                    if (cnt_inc == len) begin
                        cnt_d   = '0;
                        state_d = (state_q == LOAD_A) ? SWAP : MAC;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            SWAP: begin
                rst_add_o = 1'b1;
                state_d   = LOAD_B;
            end
            MAC: begin
                mac_ctrl_o = 1'b1;
                if (mac_done_i) state_d = READ;
            end
            READ: begin
                out_ready_o = 1'b1;
                res_d       = dataout_i;
                state_d     = RESULT;
            end
            RESULT: begin
                r_valid_o = 1'b1;
                if (r_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_o   = (state_q != IDLE);
    assign r_data_o = res_q;
    assign dimen_o  = dimen_q;

`ifdef MAC_SEQ_PERF_CNT_EN
    logic [15:0] perf_q, perf_d;

    // The accepting cycle counts as the job's first, so a clean job reads 3L+4.
    always_comb begin
        perf_d = perf_q;
        if (state_q == IDLE && start_i) begin
            perf_d = 16'd1;
        end else if (busy_o && !r_valid_o && perf_q != 16'hFFFF) begin
            perf_d = perf_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) perf_q <= '0;
        else       perf_q <= perf_d;
    end

    assign perf_cycles_o = perf_q;
`else
    assign perf_cycles_o = '0;
`endif

endmodule
